// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the pipelined data memory.
// The DATA_MEMORY_PIPE_PARITY_EN macro adds a parity-error flag to the read stage.
package data_memory_pkg;

    localparam int unsigned MAX_RD_LAT = 4;

    function automatic int unsigned byte_count(int unsigned data_w);
        return data_w / 8;
    endfunction

    // Control part of a read pipeline stage; the data word is appended by the top,
    // since its width is a parameter of the instance.
    typedef struct packed {
        logic valid;
        logic err;
`ifdef DATA_MEMORY_PIPE_PARITY_EN
        logic parity_err;
`endif
    } rd_ctrl_t;

endpackage

// File: rtl/data_memory_pipe_rd_pipe.sv
// Fixed-length shift register carrying read stages; cleared by asynchronous active-low reset.
module mem_rd_pipe #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/data_memory_pipe.sv
// Parametrised single-port data memory with byte masks, pipelined read valid and write ack.
// Optional per-byte parity checking is enabled by defining DATA_MEMORY_PIPE_PARITY_EN.
module data_memory_pipe
    import data_memory_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                request,
    input  logic                we_re,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] mask,
    output logic                ready,
    output logic                valid,
    output logic [DATA_W-1:0]   data_out,
    output logic                wr_ack,
    output logic                addr_err
`ifdef DATA_MEMORY_PIPE_PARITY_EN
    ,
    output logic                parity_err
`endif
);

    localparam int unsigned NBYTES = byte_count(DATA_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit FULL_RANGE      = (DEPTH == (1 << ADDR_W));
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic {StReset, StActive} state_e;

    typedef struct packed {
        rd_ctrl_t          ctrl;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    state_e            state_q, state_d;
    logic              accept, rd_accept, wr_accept, in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] hold_q;
    logic              wr_ack_q, wr_err_q;
    rd_stage_t         rd_in, rd_out;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StActive;
            StActive: state_d = StActive;
            default:  state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StReset;
        else      state_q <= state_d;
    end

    assign ready     = (state_q == StActive);
    assign accept    = request && ready;
    assign rd_accept = accept && !we_re;
    assign wr_accept = accept && we_re;
    assign in_range  = FULL_RANGE ? 1'b1 : ({1'b0, address} < DEPTH_LIM);
    assign idx       = address[IDX_W-1:0];

`ifdef DATA_MEMORY_PIPE_PARITY_EN
    logic [NBYTES-1:0] par_q [DEPTH];
    logic [NBYTES-1:0] par_bad;

    always_comb begin
        par_bad = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            par_bad[i] = (^mem_q[idx][8*i +: 8]) ^ par_q[idx][i];
        end
    end
`endif

    // Array and parity bits are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept && in_range) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (mask[i]) begin
                    mem_q[idx][8*i +: 8] <= data_in[8*i +: 8];
`ifdef DATA_MEMORY_PIPE_PARITY_EN
                    par_q[idx][i] <= ^data_in[8*i +: 8];
`endif
                end
            end
        end
    end

    always_comb begin
        rd_in          = '0;
        rd_in.ctrl.valid = rd_accept;
        rd_in.ctrl.err   = rd_accept && !in_range;
        if (rd_accept && in_range) rd_in.data = mem_q[idx];
`ifdef DATA_MEMORY_PIPE_PARITY_EN
        rd_in.ctrl.parity_err = rd_accept && in_range && (|par_bad);
`endif
    end

    mem_rd_pipe #(
        .WIDTH ($bits(rd_stage_t)),
        .STAGES(RD_LAT)
    ) u_rd_pipe (
        .clk(clk),
        .rst(rst),
        .d  (rd_in),
        .q  (rd_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (rd_out.ctrl.valid) hold_q <= rd_out.data;
            wr_ack_q <= wr_accept;
            wr_err_q <= wr_accept && !in_range;
        end
    end

    assign valid    = rd_out.ctrl.valid;
    assign data_out = rd_out.ctrl.valid ? rd_out.data : hold_q;
    assign wr_ack   = wr_ack_q;
    assign addr_err = (rd_out.ctrl.valid && rd_out.ctrl.err) || wr_err_q;
`ifdef DATA_MEMORY_PIPE_PARITY_EN
    assign parity_err = rd_out.ctrl.valid && rd_out.ctrl.parity_err;
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Scoreboard bench: two instances (DEPTH=200/RD_LAT=3 and DEPTH=256/RD_LAT=1) share stimulus.
module tb_data_memory_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned DEPTH_A = 200;
    localparam int unsigned LAT_A   = 3;
    localparam int unsigned DEPTH_B = 256;
    localparam int unsigned LAT_B   = 1;

    typedef struct {
        int          due;
        logic        err;
        logic        perr;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          request = 1'b0;
    logic          we_re = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    mask = '0;

    logic          ready_v [2];
    logic          valid_v [2];
    logic          wr_ack_v [2];
    logic          addr_err_v [2];
    logic [DW-1:0] data_out_v [2];
    logic          perr_v [2];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic armed = 1'b0;

    exp_t        rd_q [2][$];
    exp_t        wr_q [2][$];
    logic [31:0] model_mem [256];
    logic [3:0]  bad_par [256];
    logic [31:0] last_v [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_pipe #(.DATA_W(DW), .DEPTH(DEPTH_A), .ADDR_W(AW), .RD_LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .address(address),
        .data_in(data_in), .mask(mask), .ready(ready_v[0]), .valid(valid_v[0]),
        .data_out(data_out_v[0]), .wr_ack(wr_ack_v[0]), .addr_err(addr_err_v[0])
`ifdef DATA_MEMORY_PIPE_PARITY_EN
        , .parity_err(perr_v[0])
`endif
    );

    data_memory_pipe #(.DATA_W(DW), .DEPTH(DEPTH_B), .ADDR_W(AW), .RD_LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .address(address),
        .data_in(data_in), .mask(mask), .ready(ready_v[1]), .valid(valid_v[1]),
        .data_out(data_out_v[1]), .wr_ack(wr_ack_v[1]), .addr_err(addr_err_v[1])
`ifdef DATA_MEMORY_PIPE_PARITY_EN
        , .parity_err(perr_v[1])
`endif
    );

`ifndef DATA_MEMORY_PIPE_PARITY_EN
    initial begin
        perr_v[0] = 1'b0;
        perr_v[1] = 1'b0;
    end
`endif

    exp_t me;
    logic merr;

    // Scoreboard monitor: pops expectations as valid / wr_ack appear.
    always @(negedge clk) begin
        if (!rst) begin
            last_v[0] = '0;
            last_v[1] = '0;
        end else if (armed) begin
            for (int k = 0; k < 2; k++) begin
                merr = 1'b0;
                checks++;
                if (ready_v[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL ready[%0d] got=%b want=1", k, ready_v[k]);
                end
                if (valid_v[k] === 1'b1) begin
                    if (rd_q[k].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_valid[%0d] cyc=%0d", k, cyc);
                    end else begin
                        me = rd_q[k].pop_front();
                        merr = merr | me.err;
                        checks++;
                        if (me.due != cyc) begin
                            failures++;
                            $display("FAIL valid_timing[%0d] got_cyc=%0d want_cyc=%0d", k, cyc, me.due);
                        end
                        checks++;
                        if (data_out_v[k] !== me.data) begin
                            failures++;
                            $display("FAIL rd_data[%0d] got=%h want=%h", k, data_out_v[k], me.data);
                        end
`ifdef DATA_MEMORY_PIPE_PARITY_EN
                        checks++;
                        if (perr_v[k] !== me.perr) begin
                            failures++;
                            $display("FAIL parity_err[%0d] got=%b want=%b", k, perr_v[k], me.perr);
                        end
`endif
                        last_v[k] = me.data;
                    end
                end else begin
                    checks++;
                    if (valid_v[k] !== 1'b0 || data_out_v[k] !== last_v[k]) begin
                        failures++;
                        $display("FAIL data_hold[%0d] got=%h want=%h", k, data_out_v[k], last_v[k]);
                    end
                end
                if (wr_ack_v[k] === 1'b1) begin
                    if (wr_q[k].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_wr_ack[%0d] cyc=%0d", k, cyc);
                    end else begin
                        me = wr_q[k].pop_front();
                        merr = merr | me.err;
                        checks++;
                        if (me.due != cyc) begin
                            failures++;
                            $display("FAIL wr_ack_timing[%0d] got_cyc=%0d want_cyc=%0d", k, cyc, me.due);
                        end
                    end
                end
                checks++;
                if (addr_err_v[k] !== merr) begin
                    failures++;
                    $display("FAIL addr_err[%0d] got=%b want=%b", k, addr_err_v[k], merr);
                end
                if (rd_q[k].size() > 0 && rd_q[k][0].due < cyc) begin
                    checks++; failures++;
                    $display("FAIL missing_valid[%0d] due=%0d now=%0d", k, rd_q[k][0].due, cyc);
                    void'(rd_q[k].pop_front());
                end
                if (wr_q[k].size() > 0 && wr_q[k][0].due < cyc) begin
                    checks++; failures++;
                    $display("FAIL missing_wr_ack[%0d] due=%0d now=%0d", k, wr_q[k][0].due, cyc);
                    void'(wr_q[k].pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic we, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        exp_t e;
        request = 1'b1;
        we_re   = we;
        address = a;
        data_in = d;
        mask    = m;
        @(posedge clk);
        #1;
        request = 1'b0;
        if (we) begin
            e.due = cyc; e.perr = 1'b0; e.data = '0;
            e.err = (a >= DEPTH_A);
            wr_q[0].push_back(e);
            e.err = (a >= DEPTH_B);
            wr_q[1].push_back(e);
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    model_mem[a][8*i +: 8] = d[8*i +: 8];
                    bad_par[a][i] = 1'b0;
                end
            end
        end else begin
            e.due  = cyc + LAT_A - 1;
            e.err  = (a >= DEPTH_A);
            e.data = e.err ? 32'h0 : model_mem[a];
            e.perr = !e.err && (|bad_par[a]);
            rd_q[0].push_back(e);
            e.due  = cyc + LAT_B - 1;
            e.err  = (a >= DEPTH_B);
            e.data = e.err ? 32'h0 : model_mem[a];
            e.perr = !e.err && (|bad_par[a]);
            rd_q[1].push_back(e);
        end
    endtask

    task automatic idle(input int n, input string tag);
        request = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_q[k].size() != 0 || wr_q[k].size() != 0) begin
                failures++;
                $display("FAIL %s_drained[%0d] rd_pending=%0d wr_pending=%0d want=0",
                         tag, k, rd_q[k].size(), wr_q[k].size());
                rd_q[k].delete();
                wr_q[k].delete();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready_v[k] !== 1'b0 || valid_v[k] !== 1'b0 || wr_ack_v[k] !== 1'b0 ||
                addr_err_v[k] !== 1'b0 || data_out_v[k] !== 32'h0) begin
                failures++;
                $display("FAIL %s[%0d] got rdy=%b vld=%b ack=%b err=%b dout=%h want all 0",
                         tag, k, ready_v[k], valid_v[k], wr_ack_v[k], addr_err_v[k],
                         data_out_v[k]);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready_v[k] !== 1'b0) begin
                failures++;
                $display("FAIL ready_before_edge[%0d] got=%b want=0", k, ready_v[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready_v[k] !== 1'b1) begin
                failures++;
                $display("FAIL ready_after_edge[%0d] got=%b want=1", k, ready_v[k]);
            end
        end
        armed = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_state");
        end
        release_reset();
        idle(2, "reset_idle");
    endtask

    task automatic test_masked_write();
        do_op(1'b1, 8'h10, 32'hAABBCCDD, 4'hF);
        do_op(1'b1, 8'h10, 32'h11223344, 4'h5);
        do_op(1'b0, 8'h10, 32'h0, 4'h0);
        do_op(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0);
        do_op(1'b0, 8'h10, 32'h0, 4'h0);
        idle(5, "masked");
        checks++;
        if (model_mem[8'h10] !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL masked_model got=%h want=aa22cc44", model_mem[8'h10]);
        end
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 8'd1, 32'h1, 4'hF);
        do_op(1'b1, 8'd2, 32'h2, 4'hF);
        do_op(1'b1, 8'd3, 32'h3, 4'hF);
        do_op(1'b0, 8'd1, 32'h0, 4'h0);
        do_op(1'b0, 8'd2, 32'h0, 4'h0);
        do_op(1'b0, 8'd3, 32'h0, 4'h0);
        do_op(1'b1, 8'h20, 32'hCAFEF00D, 4'hF);
        do_op(1'b0, 8'h20, 32'h0, 4'h0);
        do_op(1'b1, 8'h21, 32'h5A5A5A5A, 4'hF);
        do_op(1'b0, 8'h21, 32'h0, 4'h0);
        idle(5, "back_to_back");
    endtask

    task automatic test_out_of_range();
        do_op(1'b1, 8'd199, 32'h19919919, 4'hF);
        do_op(1'b1, 8'd250, 32'hDEADBEEF, 4'hF);
        do_op(1'b0, 8'd250, 32'h0, 4'h0);
        do_op(1'b0, 8'd199, 32'h0, 4'h0);
        do_op(1'b0, 8'd255, 32'h0, 4'h0);
        idle(5, "out_of_range");
    endtask

    task automatic test_reset_midflight();
        do_op(1'b0, 8'd2, 32'h0, 4'h0);
        // The slow instance's read is discarded by reset; the fast one completes first.
        void'(rd_q[0].pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b0;
        #1;
        check_reset_outputs("midflight_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midflight_hold");
        release_reset();
        idle(6, "midflight");
    endtask

`ifdef DATA_MEMORY_PIPE_PARITY_EN
    task automatic test_parity();
        do_op(1'b1, 8'd5, 32'h000000FF, 4'hF);
        idle(1, "parity_wr");
        u_a.mem_q[5][0] = ~u_a.mem_q[5][0];
        u_b.mem_q[5][0] = ~u_b.mem_q[5][0];
        model_mem[5][0] = ~model_mem[5][0];
        bad_par[5][0] = 1'b1;
        do_op(1'b0, 8'd5, 32'h0, 4'h0);
        idle(5, "parity_bad");
        do_op(1'b1, 8'd5, 32'h000000FF, 4'hF);
        do_op(1'b0, 8'd5, 32'h0, 4'h0);
        do_op(1'b0, 8'd250, 32'h0, 4'h0);
        idle(5, "parity_good");
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) bad_par[i] = 4'h0;
        last_v[0] = '0;
        last_v[1] = '0;
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_out_of_range();
        test_reset_midflight();
`ifdef DATA_MEMORY_PIPE_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
